// File: rtl/dispense_change_pkg.sv
// rtl/dispense_change_pkg.sv - coin values, limits, widths and FSM states for dispense_change
package dispense_change_pkg;
  localparam int CHANGE_W = 9;
  localparam int QUART_W  = 4;
  localparam int DIM_W    = 3;
  localparam int NICK_W   = 3;
  localparam int PEN_W    = 3;

  localparam logic [CHANGE_W-1:0] COIN_QUART = 9'd25;
  localparam logic [CHANGE_W-1:0] COIN_DIME  = 9'd10;
  localparam logic [CHANGE_W-1:0] COIN_NICK  = 9'd5;
  localparam logic [CHANGE_W-1:0] MAX_CHANGE = 9'd399;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUART = 3'd1,
    S_DIME  = 3'd2,
    S_NICK  = 3'd3,
    S_PEN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/dispense_change.sv
// rtl/dispense_change.sv - greedy change decomposition into quarters, dimes, nickels, pennies
module dispense_change
  import dispense_change_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CHANGE_W-1:0] change,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [QUART_W-1:0]  quart,
  output logic [DIM_W-1:0]    dim,
  output logic [NICK_W-1:0]   nick,
  output logic [PEN_W-1:0]    pen
);

  state_t              state_q, state_d;
  logic [CHANGE_W-1:0] residual_q, residual_d;
  logic [QUART_W-1:0]  quart_q, quart_d;
  logic [DIM_W-1:0]    dim_q, dim_d;
  logic [NICK_W-1:0]   nick_q, nick_d;
  logic [PEN_W-1:0]    pen_q, pen_d;
  logic                err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      residual_q <= '0;
      quart_q    <= '0;
      dim_q      <= '0;
      nick_q     <= '0;
      pen_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      residual_q <= residual_d;
      quart_q    <= quart_d;
      dim_q      <= dim_d;
      nick_q     <= nick_d;
      pen_q      <= pen_d;
      err_q      <= err_d;
    end
  end

  // Each coin stage subtracts one coin per cycle, then spends one cycle moving on.
  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    quart_d    = quart_q;
    dim_d      = dim_q;
    nick_d     = nick_q;
    pen_d      = pen_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          quart_d = '0;
          dim_d   = '0;
          nick_d  = '0;
          pen_d   = '0;
          if (change > MAX_CHANGE) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d      = 1'b0;
            residual_d = change;
            state_d    = S_QUART;
          end
        end
      end
      S_QUART: begin
        if (residual_q >= COIN_QUART) begin
          residual_d = residual_q - COIN_QUART;
          quart_d    = quart_q + 1'b1;
        end else begin
          state_d = S_DIME;
        end
      end
      S_DIME: begin
        if (residual_q >= COIN_DIME) begin
          residual_d = residual_q - COIN_DIME;
          dim_d      = dim_q + 1'b1;
        end else begin
          state_d = S_NICK;
        end
      end
      S_NICK: begin
        if (residual_q >= COIN_NICK) begin
          residual_d = residual_q - COIN_NICK;
          nick_d     = nick_q + 1'b1;
        end else begin
          state_d = S_PEN;
        end
      end
      S_PEN: begin
        pen_d   = residual_q[PEN_W-1:0];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    err   = err_q;
    quart = quart_q;
    dim   = dim_q;
    nick  = nick_q;
    pen   = pen_q;
  end

endmodule

// File: tb/tb_dispense_change.sv
// tb/tb_dispense_change.sv - directed self-checking bench for dispense_change
module tb_dispense_change;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] change;
  logic       busy, done, err;
  logic [3:0] quart;
  logic [2:0] dim, nick, pen;

  int checks;
  int errors;

  dispense_change dut (
    .clk(clk), .rst_n(rst_n), .start(start), .change(change),
    .busy(busy), .done(done), .err(err),
    .quart(quart), .dim(dim), .nick(nick), .pen(pen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    change = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, err, quart, dim, nick, pen} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b done=%0b err=%0b q=%0d d=%0d n=%0d p=%0d want all 0",
               busy, done, err, quart, dim, nick, pen);
    end
  endtask

  // Pulses start at the next edge, then measures the accept-to-done latency and busy length.
  task automatic test_dispense(input string name, input logic [8:0] chg,
                               input int eq, input int ed, input int en, input int ep,
                               input logic ee, input int elat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    start  = 1'b1;
    change = chg;
    @(posedge clk);
    lat      = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start  = 1'b0;
      change = 9'h1ff;
      if (busy) busy_cnt++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (busy_cnt != elat) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, elat);
    end
    checks++;
    if (quart !== 4'(eq) || dim !== 3'(ed) || nick !== 3'(en) || pen !== 3'(ep) || err !== ee) begin
      errors++;
      $display("FAIL %s result got q=%0d d=%0d n=%0d p=%0d e=%0b want q=%0d d=%0d n=%0d p=%0d e=%0b",
               name, quart, dim, nick, pen, err, eq, ed, en, ep, ee);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || quart !== 4'(eq) || dim !== 3'(ed) ||
        nick !== 3'(en) || pen !== 3'(ep) || err !== ee) begin
      errors++;
      $display("FAIL %s hold got done=%0b busy=%0b q=%0d d=%0d n=%0d p=%0d e=%0b want held result, idle",
               name, done, busy, quart, dim, nick, pen, err);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    start  = 1'b1;
    change = 9'd67;
    @(posedge clk);
    @(negedge clk);
    change = 9'd41;
    repeat (3) @(negedge clk);
    start = 1'b0;
    lat   = 4;
    for (int cyc = 5; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc;
        break;
      end
    end
    checks++;
    if (lat != 9 || quart !== 4'd2 || dim !== 3'd1 || nick !== 3'd1 || pen !== 3'd2) begin
      errors++;
      $display("FAIL busy_ignore got lat=%0d q=%0d d=%0d n=%0d p=%0d want lat=9 q=2 d=1 n=1 p=2",
               lat, quart, dim, nick, pen);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen_done;
    @(negedge clk);
    start  = 1'b1;
    change = 9'd100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, err, quart, dim, nick, pen} !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%0b done=%0b err=%0b q=%0d d=%0d n=%0d p=%0d want all 0",
               busy, done, err, quart, dim, nick, pen);
    end
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL reset_mid_silent got %0d active cycles want 0", seen_done);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_dispense("chg67",  9'd67,  2, 1, 1, 2, 1'b0, 9);
    test_dispense("chg0",   9'd0,   0, 0, 0, 0, 1'b0, 5);
    test_dispense("chg399", 9'd399, 15, 2, 0, 4, 1'b0, 22);
    test_dispense("chg41",  9'd41,  1, 1, 1, 1, 1'b0, 8);
    test_dispense("chg400", 9'd400, 0, 0, 0, 0, 1'b1, 1);
    test_dispense("chg30",  9'd30,  1, 0, 1, 0, 1'b0, 7);
    test_dispense("chg511", 9'd511, 0, 0, 0, 0, 1'b1, 1);
    test_dispense("chg24",  9'd24,  0, 2, 0, 4, 1'b0, 7);
    test_busy_ignore();
    test_dispense("chg67b", 9'd67,  2, 1, 1, 2, 1'b0, 9);
    test_reset_mid();
    test_dispense("after_rst", 9'd67, 2, 1, 1, 2, 1'b0, 9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dispense_change.md
DISPENSE_CHANGE -- requirements
Module: dispense_change

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Port list: clk  input  1  system clock.
REQ-003 Port list: rst_n  input  1  synchronous active-low reset.
REQ-004 Port list: start  input  1  request; samples change when block idle.
REQ-005 Port list: change  input  9  amount to return, unsigned cents (0..511).
REQ-006 Port list: busy  output  1  high from accepted start until done cycle inclusive.
REQ-007 Port list: done  output  1  one-cycle pulse, result valid.
REQ-008 Port list: err  output  1  change out of range; held with result.
REQ-009 Port list: quart  output  4  number of quarters (25c).
REQ-010 Port list: dim  output  3  number of dimes (10c).
REQ-011 Port list: nick  output  3  number of nickels (5c).
REQ-012 Port list: pen  output  3  number of pennies (1c).

Function
REQ-013 States SHALL be IDLE, QUART, DIME, NICK, PEN, DONE; outputs decoded from state (Moore).
REQ-014 IDLE: start=1 with change<=399 SHALL capture change into 9-bit residual, clear all counts and err, go QUART.
REQ-015 IDLE: start=1 with change>399 SHALL clear all counts, set err=1, go DONE.
REQ-016 QUART: residual>=25 -> subtract 25, quart+1, stay; else -> DIME (one cycle, no subtraction).
REQ-017 DIME: residual>=10 -> subtract 10, dim+1, stay; else -> NICK.
REQ-018 NICK: residual>=5 -> subtract 5, nick+1, stay; else -> PEN.
REQ-019 PEN: pen SHALL be loaded with residual (0..4) in one cycle; -> DONE.
REQ-020 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-021 Result SHALL be the greedy decomposition: quart=change/25, dim<=2, nick<=1, pen<=4; sum of coin values equals change.
REQ-022 Latency, start edge to done-high cycle: quart+dim+nick+5 cycles for valid change; 1 cycle for err case.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 start SHALL be ignored while busy; change SHALL be sampled only on the accepting edge.
REQ-025 quart/dim/nick/pen/err SHALL hold their last result after DONE until the next accepted start clears them.
REQ-026 Counters SHALL never wrap: 399 is the largest accepted value (15 quarters).

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE and set busy=0, done=0, err=0, quart=0, dim=0, nick=0, pen=0, residual=0.
REQ-028 Reset mid-operation SHALL abort silently: no done pulse; start is honoured on the first edge after rst_n returns to 1.

Structure
REQ-029 A shared package SHALL hold the coin values (25, 10, 5), MAX_CHANGE=399, the count widths and the state enumeration.
REQ-030 The block SHALL be a single module with no sub-modules; one FSM plus residual and count registers.

Verification
REQ-031 change=67, start pulse -> quart=2, dim=1, nick=1, pen=2, err=0; done 9 cycles after start; busy high 9 cycles.
REQ-032 change=0 -> all counts 0, err=0; done 5 cycles after start.
REQ-033 change=399 -> quart=15, dim=2, nick=0, pen=4; done 22 cycles after start. change=41 -> 1,1,1,1; done 8 cycles after start.
REQ-034 change=400 and change=511 -> err=1, all counts 0; done 1 cycle after start.
REQ-035 Second start while busy is ignored. rst_n=0 during QUART -> IDLE, all outputs 0, no done pulse. The next start works normally.
